// File: rtl/ipif_mst_responder.sv
// IPIF master-command target: takes single-beat read/write commands from the DMA
// engine's master port, runs them against a simple register backend and reports completion.
module ipif_mst_responder #(
    parameter logic [31:0] BASE_ADDR      = 32'h7000_0000,
    parameter int          ADDR_BITS      = 16,
    parameter int          TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ERR_RD_DATA    = 32'hDEAD_BEEF
) (
    input  logic                 axi_clk,
    input  logic                 rst,
    input  logic                 IP2Bus_MstRd_Req,
    input  logic                 IP2Bus_MstWr_Req,
    input  logic [31:0]          IP2Bus_Mst_Addr,
    input  logic [3:0]           IP2Bus_Mst_BE,
    input  logic                 IP2Bus_Mst_Lock,
    input  logic                 IP2Bus_Mst_Reset,
    input  logic [31:0]          IP2Bus_MstWr_d,
    output logic                 Bus2IP_Mst_CmdAck,
    output logic                 Bus2IP_Mst_Cmplt,
    output logic                 Bus2IP_Mst_Error,
    output logic                 Bus2IP_Mst_Rearbitrate,
    output logic                 Bus2IP_Mst_Timeout,
    output logic [31:0]          Bus2IP_MstRd_d,
    output logic                 Bus2IP_MstRd_src_rdy_n,
    output logic                 Bus2IP_MstWr_dst_rdy_n,
    output logic                 reg_req,
    output logic                 reg_wr,
    output logic [ADDR_BITS-3:0] reg_addr,
    output logic [3:0]           reg_be,
    output logic [31:0]          reg_wdata,
    input  logic                 reg_ack,
    input  logic                 reg_err,
    input  logic [31:0]          reg_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACK    = 3'd1,
        ST_ACCESS = 3'd2,
        ST_DATA   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t            state_r, state_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic [31:0]       addr_r, addr_s;
    logic [3:0]        be_r, be_s;
    logic              wr_r, wr_s;
    logic [31:0]       wdata_r, wdata_s;
    logic [31:0]       rdata_r, rdata_s;
    logic              err_r, err_s;
    logic              tmo_r, tmo_s;
    logic              dec_err_s;
    logic              cmd_ack_r, cmplt_r, error_r, timeout_r;
    logic              src_rdy_n_r, dst_rdy_n_r, reg_req_r;
    logic              unused_lock_s;

    assign unused_lock_s = IP2Bus_Mst_Lock;

    // Only the bits above the window size select this target; addresses must be word aligned.
    assign dec_err_s = (addr_r[31:ADDR_BITS] != BASE_ADDR[31:ADDR_BITS]) || (addr_r[1:0] != 2'b00);

    // Next-state and datapath update for the command sequencer.
    always_comb begin
        state_s = state_r;
        cnt_s   = CNT_ZERO;
        addr_s  = addr_r;
        be_s    = be_r;
        wr_s    = wr_r;
        wdata_s = wdata_r;
        rdata_s = rdata_r;
        err_s   = err_r;
        tmo_s   = tmo_r;
        if (IP2Bus_Mst_Reset) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (IP2Bus_MstRd_Req || IP2Bus_MstWr_Req) begin
                        addr_s  = IP2Bus_Mst_Addr;
                        be_s    = IP2Bus_Mst_BE;
                        wr_s    = ~IP2Bus_MstRd_Req;
                        err_s   = 1'b0;
                        tmo_s   = 1'b0;
                        state_s = ST_ACK;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_ACK: begin
                    wdata_s = IP2Bus_MstWr_d;
                    if (dec_err_s) begin
                        err_s   = 1'b1;
                        rdata_s = ERR_RD_DATA;
                        state_s = ST_DATA;
                    end else if (wr_r && (be_r == 4'h0)) begin
                        state_s = ST_DATA;
                    end else begin
                        state_s = ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // An ack landing in the last allowed cycle still counts as a normal finish.
                    if (reg_ack) begin
                        rdata_s = reg_rdata;
                        err_s   = reg_err;
                        state_s = ST_DATA;
                    end else if (cnt_r == TMO_LAST) begin
                        rdata_s = ERR_RD_DATA;
                        err_s   = 1'b1;
                        tmo_s   = 1'b1;
                        state_s = ST_DATA;
                    end else begin
                        cnt_s   = cnt_r + CNT_ONE;
                        state_s = ST_ACCESS;
                    end
                end
                ST_DATA: state_s = ST_DONE;
                ST_DONE: state_s = ST_IDLE;
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // Sequencer state, latched command fields and captured response.
    always_ff @(posedge axi_clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            addr_r  <= 32'h0000_0000;
            be_r    <= 4'h0;
            wr_r    <= 1'b0;
            wdata_r <= 32'h0000_0000;
            rdata_r <= 32'h0000_0000;
            err_r   <= 1'b0;
            tmo_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            addr_r  <= addr_s;
            be_r    <= be_s;
            wr_r    <= wr_s;
            wdata_r <= wdata_s;
            rdata_r <= rdata_s;
            err_r   <= err_s;
            tmo_r   <= tmo_s;
        end
    end

    // Handshake outputs are decoded from the next state so they line up with the state they belong to.
    always_ff @(posedge axi_clk) begin
        if (rst) begin
            cmd_ack_r   <= 1'b0;
            cmplt_r     <= 1'b0;
            error_r     <= 1'b0;
            timeout_r   <= 1'b0;
            src_rdy_n_r <= 1'b1;
            dst_rdy_n_r <= 1'b1;
            reg_req_r   <= 1'b0;
        end else begin
            cmd_ack_r   <= (state_s == ST_ACK);
            cmplt_r     <= (state_s == ST_DONE);
            error_r     <= (state_s == ST_DONE) && err_s;
            timeout_r   <= (state_s == ST_DONE) && tmo_s;
            src_rdy_n_r <= ~((state_s == ST_DATA) && ~wr_s);
            dst_rdy_n_r <= ~((state_s == ST_DATA) && wr_s);
            reg_req_r   <= (state_s == ST_ACCESS);
        end
    end

    assign Bus2IP_Mst_CmdAck      = cmd_ack_r;
    assign Bus2IP_Mst_Cmplt       = cmplt_r;
    assign Bus2IP_Mst_Error       = error_r;
    assign Bus2IP_Mst_Timeout     = timeout_r;
    assign Bus2IP_Mst_Rearbitrate = 1'b0;
    assign Bus2IP_MstRd_d         = rdata_r;
    assign Bus2IP_MstRd_src_rdy_n = src_rdy_n_r;
    assign Bus2IP_MstWr_dst_rdy_n = dst_rdy_n_r;
    assign reg_req                = reg_req_r;
    assign reg_wr                 = wr_r;
    assign reg_addr               = addr_r[ADDR_BITS-1:2];
    assign reg_be                 = be_r;
    assign reg_wdata              = wdata_r;

endmodule

// File: tb/tb_ipif_mst_responder.sv
// Directed bench for ipif_mst_responder: a transaction-level timeline model predicts every
// handshake cycle; literal expectations pin the documented scenarios.
module tb_ipif_mst_responder;

    localparam int MAXC = 4096;
    localparam int NEVER = 100000;

    logic        axi_clk = 1'b0;
    logic        rst;
    logic        IP2Bus_MstRd_Req, IP2Bus_MstWr_Req, IP2Bus_Mst_Lock, IP2Bus_Mst_Reset;
    logic [31:0] IP2Bus_Mst_Addr, IP2Bus_MstWr_d;
    logic [3:0]  IP2Bus_Mst_BE;
    logic        Bus2IP_Mst_CmdAck, Bus2IP_Mst_Cmplt, Bus2IP_Mst_Error;
    logic        Bus2IP_Mst_Rearbitrate, Bus2IP_Mst_Timeout;
    logic [31:0] Bus2IP_MstRd_d;
    logic        Bus2IP_MstRd_src_rdy_n, Bus2IP_MstWr_dst_rdy_n;
    logic        reg_req, reg_wr, reg_ack, reg_err;
    logic [13:0] reg_addr;
    logic [3:0]  reg_be;
    logic [31:0] reg_wdata, reg_rdata;

    // backend stand-in
    logic        bk_ack = 1'b0, late_ack = 1'b0, bk_err = 1'b0;
    logic [31:0] bk_rdata = 32'h0;
    int          bk_delay = 0, bk_cnt = 0;
    assign reg_ack   = bk_ack | late_ack;
    assign reg_err   = bk_err;
    assign reg_rdata = bk_rdata;

    ipif_mst_responder dut (
        .axi_clk(axi_clk), .rst(rst),
        .IP2Bus_MstRd_Req(IP2Bus_MstRd_Req), .IP2Bus_MstWr_Req(IP2Bus_MstWr_Req),
        .IP2Bus_Mst_Addr(IP2Bus_Mst_Addr), .IP2Bus_Mst_BE(IP2Bus_Mst_BE),
        .IP2Bus_Mst_Lock(IP2Bus_Mst_Lock), .IP2Bus_Mst_Reset(IP2Bus_Mst_Reset),
        .IP2Bus_MstWr_d(IP2Bus_MstWr_d),
        .Bus2IP_Mst_CmdAck(Bus2IP_Mst_CmdAck), .Bus2IP_Mst_Cmplt(Bus2IP_Mst_Cmplt),
        .Bus2IP_Mst_Error(Bus2IP_Mst_Error), .Bus2IP_Mst_Rearbitrate(Bus2IP_Mst_Rearbitrate),
        .Bus2IP_Mst_Timeout(Bus2IP_Mst_Timeout), .Bus2IP_MstRd_d(Bus2IP_MstRd_d),
        .Bus2IP_MstRd_src_rdy_n(Bus2IP_MstRd_src_rdy_n),
        .Bus2IP_MstWr_dst_rdy_n(Bus2IP_MstWr_dst_rdy_n),
        .reg_req(reg_req), .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_be(reg_be),
        .reg_wdata(reg_wdata), .reg_ack(reg_ack), .reg_err(reg_err), .reg_rdata(reg_rdata)
    );

    always #5 axi_clk = ~axi_clk;

    int cyc = 0;
    int errs = 0, checks = 0;
    bit chk_en = 1'b0;

    // expected timeline, indexed by cycle
    bit          exp_ack[MAXC], exp_req[MAXC], exp_src[MAXC], exp_dst[MAXC], exp_cmplt[MAXC];
    bit          exp_err[MAXC], exp_tmo[MAXC];
    logic [31:0] exp_rd[MAXC];
    logic [13:0] m_addr;
    logic        m_wr;
    logic [3:0]  m_be;
    logic [31:0] m_wd;

    // per-transaction observations
    int          req_cnt, src_cnt, dst_cnt, cmplt_cnt, ack_cyc, cmplt_cyc;
    logic [13:0] cap_addr;
    logic        cap_wr, cap_err, cap_tmo;
    logic [3:0]  cap_be;
    logic [31:0] cap_wd, cap_rd;

    function automatic logic [31:0] b(input logic x);
        return {31'b0, x};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errs++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    initial forever begin
        @(posedge axi_clk);
        cyc++;
    end

    initial forever begin
        @(posedge axi_clk); #1;
        if (reg_req) begin
            bk_ack = (bk_cnt == bk_delay);
            bk_cnt++;
        end else begin
            bk_ack = 1'b0;
            bk_cnt = 0;
        end
    end

    // cycle-by-cycle comparison against the model timeline
    initial forever begin
        @(negedge axi_clk);
        if (chk_en && cyc < MAXC) begin
            chk("cmd_ack", b(Bus2IP_Mst_CmdAck), b(exp_ack[cyc]));
            chk("cmplt", b(Bus2IP_Mst_Cmplt), b(exp_cmplt[cyc]));
            chk("src_rdy_n", b(Bus2IP_MstRd_src_rdy_n), b(!exp_src[cyc]));
            chk("dst_rdy_n", b(Bus2IP_MstWr_dst_rdy_n), b(!exp_dst[cyc]));
            chk("reg_req", b(reg_req), b(exp_req[cyc]));
            chk("rearb", b(Bus2IP_Mst_Rearbitrate), 32'h0);
            if (exp_src[cyc]) chk("rd_data", Bus2IP_MstRd_d, exp_rd[cyc]);
            if (exp_cmplt[cyc]) begin
                chk("error", b(Bus2IP_Mst_Error), b(exp_err[cyc]));
                chk("timeout", b(Bus2IP_Mst_Timeout), b(exp_tmo[cyc]));
            end
            if (exp_req[cyc]) begin
                chk("reg_addr", {18'b0, reg_addr}, {18'b0, m_addr});
                chk("reg_wr", b(reg_wr), b(m_wr));
                chk("reg_be", {28'b0, reg_be}, {28'b0, m_be});
                if (m_wr) chk("reg_wdata", reg_wdata, m_wd);
            end
        end
    end

    initial forever begin
        @(negedge axi_clk);
        if (reg_req) begin
            req_cnt++; cap_addr = reg_addr; cap_wr = reg_wr; cap_be = reg_be; cap_wd = reg_wdata;
        end
        if (Bus2IP_Mst_CmdAck) ack_cyc = cyc;
        if (!Bus2IP_MstRd_src_rdy_n) begin src_cnt++; cap_rd = Bus2IP_MstRd_d; end
        if (!Bus2IP_MstWr_dst_rdy_n) dst_cnt++;
        if (Bus2IP_Mst_Cmplt) begin
            cmplt_cnt++; cmplt_cyc = cyc; cap_err = Bus2IP_Mst_Error; cap_tmo = Bus2IP_Mst_Timeout;
        end
    end

    // One command: predict its timeline, drive it, optionally abort it with Mst_Reset at cycle t+rst_at.
    task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] wd, input int delay, input logic [31:0] rdata,
                           input logic rerr, input int rst_at, output int t);
        int n, dcyc, lim, end_c;
        logic dec_err, tmo, err;
        @(posedge axi_clk); #1;
        t = cyc;
        req_cnt = 0; src_cnt = 0; dst_cnt = 0; cmplt_cnt = 0; ack_cyc = -1; cmplt_cyc = -1;
        dec_err = (addr[31:16] != 16'h7000) || (addr[1:0] != 2'b00);
        if (dec_err || (!rd && be == 4'h0)) begin n = 0; tmo = 1'b0; err = dec_err; end
        else if (delay < 256) begin n = delay + 1; tmo = 1'b0; err = rerr; end
        else begin n = 256; tmo = 1'b1; err = 1'b1; end
        dcyc = t + 2 + n;
        lim  = (rst_at > 0) ? t + rst_at : MAXC - 2;
        m_addr = addr[15:2]; m_wr = !rd; m_be = be; m_wd = wd;
        if (t + 1 <= lim) exp_ack[t + 1] = 1'b1;
        for (int c = t + 2; c < t + 2 + n; c++) if (c <= lim) exp_req[c] = 1'b1;
        if (dcyc <= lim) begin
            exp_src[dcyc] = rd; exp_dst[dcyc] = !rd;
            exp_rd[dcyc] = (dec_err || tmo) ? 32'hDEAD_BEEF : rdata;
        end
        if (dcyc + 1 <= lim) begin
            exp_cmplt[dcyc + 1] = 1'b1; exp_err[dcyc + 1] = err; exp_tmo[dcyc + 1] = tmo;
        end
        end_c = (rst_at > 0) ? lim + 1 : dcyc + 1;
        IP2Bus_MstRd_Req = rd; IP2Bus_MstWr_Req = wr; IP2Bus_Mst_Addr = addr;
        IP2Bus_Mst_BE = be; IP2Bus_MstWr_d = wd;
        bk_delay = delay; bk_rdata = rdata; bk_err = rerr;
        @(posedge axi_clk); #1;
        @(posedge axi_clk); #1;
        IP2Bus_MstRd_Req = 1'b0; IP2Bus_MstWr_Req = 1'b0;
        if (rst_at > 0) begin
            while (cyc < t + rst_at) begin @(posedge axi_clk); #1; end
            IP2Bus_Mst_Reset = 1'b1;
            @(posedge axi_clk); #1;
            IP2Bus_Mst_Reset = 1'b0; late_ack = 1'b1;
            @(posedge axi_clk); #1;
            late_ack = 1'b0;
        end
        while (cyc < end_c + 1) begin @(posedge axi_clk); #1; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst = 1'b1;
        IP2Bus_MstRd_Req = 1'b0; IP2Bus_MstWr_Req = 1'b0; IP2Bus_Mst_Lock = 1'b0;
        IP2Bus_Mst_Reset = 1'b0; IP2Bus_Mst_Addr = 32'h0; IP2Bus_Mst_BE = 4'h0; IP2Bus_MstWr_d = 32'h0;
        repeat (3) @(posedge axi_clk);
        @(negedge axi_clk);
        chk("rst_cmdack", b(Bus2IP_Mst_CmdAck), 32'h0);
        chk("rst_cmplt", b(Bus2IP_Mst_Cmplt), 32'h0);
        chk("rst_error", b(Bus2IP_Mst_Error), 32'h0);
        chk("rst_timeout", b(Bus2IP_Mst_Timeout), 32'h0);
        chk("rst_src_rdy_n", b(Bus2IP_MstRd_src_rdy_n), 32'h1);
        chk("rst_dst_rdy_n", b(Bus2IP_MstWr_dst_rdy_n), 32'h1);
        chk("rst_rd_d", Bus2IP_MstRd_d, 32'h0);
        chk("rst_reg_req", b(reg_req), 32'h0);
        chk("rst_reg_wr", b(reg_wr), 32'h0);
        chk("rst_reg_addr", {18'b0, reg_addr}, 32'h0);
        chk("rst_reg_be", {28'b0, reg_be}, 32'h0);
        chk("rst_reg_wdata", reg_wdata, 32'h0);
        @(posedge axi_clk); #1;
        rst = 1'b0;
        chk_en = 1'b1;

        // zero-wait read
        run_txn(1'b1, 1'b0, 32'h7000_0010, 4'hF, 32'h0, 0, 32'h1234_5678, 1'b0, 0, t);
        chk("rd0_ack_lat", 32'(ack_cyc - t), 32'd1);
        chk("rd0_cmplt_lat", 32'(cmplt_cyc - t), 32'd4);
        chk("rd0_addr", {18'b0, cap_addr}, 32'h4);
        chk("rd0_data", cap_rd, 32'h1234_5678);
        chk("rd0_err", b(cap_err), 32'h0);

        // write with a slow backend
        run_txn(1'b0, 1'b1, 32'h7000_0004, 4'h3, 32'hA5A5_A5A5, 5, 32'h0, 1'b0, 0, t);
        chk("wr_reg_wr", b(cap_wr), 32'h1);
        chk("wr_reg_be", {28'b0, cap_be}, 32'h3);
        chk("wr_reg_wdata", cap_wd, 32'hA5A5_A5A5);
        chk("wr_dst_cnt", dst_cnt, 32'd1);
        chk("wr_src_cnt", src_cnt, 32'd0);
        chk("wr_cmplt_cnt", cmplt_cnt, 32'd1);
        chk("wr_err", b(cap_err), 32'h0);

        // outside the window
        run_txn(1'b1, 1'b0, 32'h8000_0000, 4'hF, 32'h0, 0, 32'h5555_5555, 1'b0, 0, t);
        chk("dec_req_cnt", req_cnt, 32'd0);
        chk("dec_data", cap_rd, 32'hDEAD_BEEF);
        chk("dec_err", b(cap_err), 32'h1);
        chk("dec_tmo", b(cap_tmo), 32'h0);

        // backend never answers
        run_txn(1'b1, 1'b0, 32'h7000_0020, 4'hF, 32'h0, NEVER, 32'h0, 1'b0, 0, t);
        chk("tmo_req_cnt", req_cnt, 32'd256);
        chk("tmo_data", cap_rd, 32'hDEAD_BEEF);
        chk("tmo_err", b(cap_err), 32'h1);
        chk("tmo_tmo", b(cap_tmo), 32'h1);

        // ack in the final allowed cycle beats the timeout
        run_txn(1'b1, 1'b0, 32'h7000_0024, 4'hF, 32'h0, 255, 32'h1111_2222, 1'b0, 0, t);
        chk("late_req_cnt", req_cnt, 32'd256);
        chk("late_data", cap_rd, 32'h1111_2222);
        chk("late_tmo", b(cap_tmo), 32'h0);

        // both requests: read wins, backend error
        run_txn(1'b1, 1'b1, 32'h7000_0008, 4'hF, 32'h0BAD_0BAD, 2, 32'hCAFE_0001, 1'b1, 0, t);
        chk("both_reg_wr", b(cap_wr), 32'h0);
        chk("both_err", b(cap_err), 32'h1);
        chk("both_tmo", b(cap_tmo), 32'h0);
        chk("both_src_cnt", src_cnt, 32'd1);

        // abort during ACCESS, then a stray ack
        run_txn(1'b1, 1'b0, 32'h7000_000C, 4'hF, 32'h0, NEVER, 32'h7777_7777, 1'b0, 3, t);
        chk("abort_cmplt_cnt", cmplt_cnt, 32'd0);
        chk("abort_src_cnt", src_cnt, 32'd0);

        run_txn(1'b1, 1'b0, 32'h7000_0030, 4'hF, 32'h0, 1, 32'h0BAD_F00D, 1'b0, 0, t);
        chk("post_abort_data", cap_rd, 32'h0BAD_F00D);
        chk("post_abort_cmplt", 32'(cmplt_cyc - t), 32'd5);

        // write with no byte lanes: no backend access
        run_txn(1'b0, 1'b1, 32'h7000_0040, 4'h0, 32'h1234_0000, 0, 32'h0, 1'b0, 0, t);
        chk("nobe_req_cnt", req_cnt, 32'd0);
        chk("nobe_dst_cnt", dst_cnt, 32'd1);
        chk("nobe_err", b(cap_err), 32'h0);

        // misaligned read
        run_txn(1'b1, 1'b0, 32'h7000_0002, 4'hF, 32'h0, 0, 32'h0, 1'b0, 0, t);
        chk("mis_req_cnt", req_cnt, 32'd0);
        chk("mis_err", b(cap_err), 32'h1);

        // top word of the window
        run_txn(1'b0, 1'b1, 32'h7000_FFFC, 4'hF, 32'h0F0F_F0F0, 0, 32'h0, 1'b0, 0, t);
        chk("top_addr", {18'b0, cap_addr}, 32'h3FFF);
        chk("top_err", b(cap_err), 32'h0);

        repeat (2) @(posedge axi_clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
